// File: rtl/sram_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_array_ctrl
//  Purpose  : Word-wide single-port SRAM array (DEPTH = 2**ADDR_W words of
//             DATA_W bits) behind a valid/ready request port, with a one-cycle
//             registered read response and a hardware sequencer that clears
//             every word to INIT_VAL.
//  Ports    : clk        - clock, all state changes on the rising edge
//             rst_n      - synchronous reset, active low
//             req_valid  - request present
//             req_ready  - request can be accepted this cycle (combinational)
//             req_rw     - 1 = write, 0 = read
//             req_addr   - word address
//             req_wdata  - write data
//             rsp_valid  - one-cycle pulse, rsp_rdata holds a new read result
//             rsp_rdata  - read data, held until the next read completes
//             clr_start  - start a full-array clear to INIT_VAL
//             clr_busy   - clear sequence in progress
//  Revision : 1.0 - initial release
// ============================================================================
module sram_array_ctrl #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clr_start,
  output logic              clr_busy
);

  localparam int                DEPTH       = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_last_addr = '1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                clr_busy_q, clr_busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  // Storage is deliberately not reset: contents are undefined at power-up.
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                w_accept;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_waddr;
  logic [DATA_W-1:0]   w_mem_wdata;

  // Clear start wins over a request presented in the same cycle.
  assign req_ready = (state_q == ST_IDLE) && !clr_start;
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_busy_d  = clr_busy_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    w_mem_we    = 1'b0;
    w_mem_waddr = req_addr;
    w_mem_wdata = req_wdata;

    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d    = ST_CLEAR;
          clr_cnt_d  = '0;
          clr_busy_d = 1'b1;
        end else if (w_accept) begin
          if (req_rw) begin
            w_mem_we = 1'b1;
          end else begin
            // Read data is captured at the accepting edge: one-cycle latency.
            rsp_valid_d = 1'b1;
            rsp_rdata_d = mem[req_addr];
          end
        end
      end
      ST_CLEAR: begin
        // One word per cycle; the counter wraps back to 0 on the last word.
        w_mem_we    = 1'b1;
        w_mem_waddr = clr_cnt_q;
        w_mem_wdata = INIT_VAL;
        clr_cnt_d   = clr_cnt_q + 1'b1;
        if (clr_cnt_q == c_last_addr) begin
          state_d    = ST_IDLE;
          clr_busy_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        clr_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      clr_busy_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_busy_q  <= clr_busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Writes are suppressed while reset is asserted so that an interrupted
  // clear leaves the not-yet-visited words untouched.
  always_ff @(posedge clk) begin
    if (w_mem_we && rst_n) begin
      mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign clr_busy  = clr_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_array_ctrl
//  Purpose  : Directed self-checking bench for sram_array_ctrl. Inputs change
//             1 ns after a rising edge; registered outputs are sampled 1 ns
//             after the rising edge that updates them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_array_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              clr_start;
  logic              clr_busy;

  int checks = 0;
  int errors = 0;

  sram_array_ctrl #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .INIT_VAL(8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rw   (req_rw),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .clr_start(clr_start),
    .clr_busy (clr_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    clr_start = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = a; req_wdata = d;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rsp_valid=%b rsp_rdata=%h clr_busy=%b, want 0/00/0",
               rsp_valid, rsp_rdata, clr_busy);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_rw();
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_no_rsp: rsp_valid=%b want 0", rsp_valid);
    end
    req_rw = 1'b0; req_wdata = 8'hxx;
    tick();
    idle_inputs();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL read_a5: rsp_valid=%b rsp_rdata=%h want 1/a5", rsp_valid, rsp_rdata);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL read_pulse_hold: rsp_valid=%b rsp_rdata=%h want 0/a5", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    for (int i = 0; i < 16; i++) wr(4'(i), 8'(i * 8'h11));
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'(i);
      tick();
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'(i * 8'h11)) begin
        bad++;
        $display("FAIL b2b_read[%0d]: rsp_valid=%b rsp_rdata=%h want 1/%h",
                 i, rsp_valid, rsp_rdata, 8'(i * 8'h11));
      end
    end
    idle_inputs();
    checks++;
    if (bad != 0) errors++;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  // Runs a clear started in the current cycle and returns its busy length.
  task automatic run_clear(output int busy_cycles, output int ready_bad);
    busy_cycles = 0;
    ready_bad   = 0;
    clr_start = 1'b1;
    #1;
    if (req_ready !== 1'b0) ready_bad++;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 40 && clr_busy === 1'b1; k++) begin
      busy_cycles++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) ready_bad++;
      tick();
    end
  endtask

  task automatic test_clear();
    int busy, rbad, bad;
    run_clear(busy, rbad);
    checks++;
    if (busy != 16) begin
      errors++;
      $display("FAIL clear_len: busy %0d cycles want 16", busy);
    end
    checks++;
    if (rbad != 0) begin
      errors++;
      $display("FAIL clear_ready: %0d cycles with req_ready/rsp_valid high, want 0", rbad);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'(i);
      tick();
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00) begin
        bad++;
        $display("FAIL clear_read[%0d]: rsp_valid=%b rsp_rdata=%h want 1/00", i, rsp_valid, rsp_rdata);
      end
    end
    idle_inputs();
    checks++;
    if (bad != 0) errors++;
  endtask

  task automatic test_clear_priority();
    int waited = 0;
    int bad = 0;
    wr(4'd9, 8'h77);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'd9;
    clr_start = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_ready: got %b want 0", req_ready);
    end
    tick();
    clr_start = 1'b0;
    while (req_ready !== 1'b1 && waited < 40) begin
      if (rsp_valid !== 1'b0) bad++;
      waited++;
      tick();
    end
    checks++;
    if (waited != 16 || bad != 0) begin
      errors++;
      $display("FAIL prio_hold: waited %0d cycles with %0d responses, want 16/0", waited, bad);
    end
    tick();
    idle_inputs();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL prio_read: rsp_valid=%b rsp_rdata=%h want 1/00", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_reset_during_clear();
    int bad = 0;
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) wr(4'(i), 8'(8'hA0 + i));
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 5; k++) tick();   // words 0..4 cleared
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (clr_busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstclr_state: clr_busy=%b req_ready=%b want 0/1", clr_busy, req_ready);
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 5) ? 8'h00 : 8'(8'hA0 + i);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'(i);
      tick();
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
        bad++;
        $display("FAIL rstclr_read[%0d]: rsp_valid=%b rsp_rdata=%h want 1/%h", i, rsp_valid, rsp_rdata, exp);
      end
    end
    idle_inputs();
    checks++;
    if (bad != 0) errors++;
  endtask

  task automatic test_raw_and_drop();
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 4'd7; req_wdata = 8'h3C;
    tick();
    req_rw = 1'b0; req_wdata = 8'hxx;
    tick();
    idle_inputs();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL raw_read: rsp_valid=%b rsp_rdata=%h want 1/3c", rsp_valid, rsp_rdata);
    end
    // Read accepted together with reset: the response must be dropped.
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'd7;
    rst_n = 1'b0;
    tick();
    idle_inputs();
    rst_n = 1'b1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL drop_same: rsp_valid=%b rsp_rdata=%h want 0/00", rsp_valid, rsp_rdata);
    end
    // Read, then reset in the following cycle clears the response.
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'd7;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL drop_next: rsp_valid=%b rsp_rdata=%h want 0/00", rsp_valid, rsp_rdata);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_rw();
    test_back_to_back();
    test_clear();
    test_clear_priority();
    test_reset_during_clear();
    test_raw_and_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
